// File: rtl/video_vga_timing.sv
// VGA timing generator with line-buffer scanout.
// Counters x/y drive sync/active generation, horizontal and vertical pixel
// replication, per-row fetch requests and a latency-matching delay pipeline
// so sync, data enable and colour reach the pins in the same clock.
module video_vga_timing #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FRONT_PORCH   = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK_PORCH    = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FRONT_PORCH   = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK_PORCH    = 33,
  parameter int HSYNC_POL       = 0,
  parameter int VSYNC_POL       = 0,
  parameter int COLOR_BITS      = 4,
  parameter int IDX_W           = 11,
  parameter int LINEBUF_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              pixel_width,
  input  logic [1:0]              pixel_height,
  output logic [IDX_W-1:0]        linebuf_idx,
  input  logic [3*COLOR_BITS-1:0] linebuf_rgb_data,
  output logic                    line_req,
  output logic [9:0]              line_idx,
  output logic                    frame_start,
  output logic [COLOR_BITS-1:0]   vga_r,
  output logic [COLOR_BITS-1:0]   vga_g,
  output logic [COLOR_BITS-1:0]   vga_b,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic                    vga_de
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam int XW       = $clog2(H_TOTAL);
  localparam int YW       = $clog2(V_TOTAL);
  localparam int HS_START = H_ACTIVE + H_FRONT_PORCH;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT_PORCH;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int CW       = 3 * COLOR_BITS;
  localparam int LAT      = LINEBUF_LATENCY;

  localparam logic [XW-1:0]    X_ONE   = XW'(1);
  localparam logic [YW-1:0]    Y_ONE   = YW'(1);
  localparam logic [XW-1:0]    X_LAST  = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0]    Y_LAST  = YW'(V_TOTAL - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic             HS_ON   = (HSYNC_POL != 0);
  localparam logic             VS_ON   = (VSYNC_POL != 0);

  logic [XW-1:0]    x_r;
  logic [YW-1:0]    y_r;
  logic [1:0]       pw_r;
  logic [1:0]       ph_r;
  logic [1:0]       hc_r;
  logic [1:0]       vc_r;
  logic [IDX_W-1:0] idx_r;
  logic [9:0]       line_idx_r;
  logic             line_req_r;
  logic             frame_start_r;
  logic [2:0]       pipe_r [LAT];
  logic [CW-1:0]    rgb_r;
  logic             hsync_r;
  logic             vsync_r;
  logic             de_r;

  logic             h_last_s;
  logic             v_last_s;
  logic             frame_end_s;
  logic             hsync_s;
  logic             vsync_s;
  logic             active_s;
  logic             row_active_s;
  logic             next_row_active_s;
  logic             line_adv_s;
  logic             h_scan_s;
  logic [1:0]       pw_next_s;
  logic [1:0]       ph_next_s;
  logic [2:0]       pipe_out_s;

  // Decode counter state into timing strobes and next-row information.
  always_comb begin
    h_last_s          = (x_r == X_LAST);
    v_last_s          = (y_r == Y_LAST);
    frame_end_s       = h_last_s && v_last_s;
    hsync_s           = (32'(x_r) >= HS_START) && (32'(x_r) < HS_END);
    vsync_s           = (32'(y_r) >= VS_START) && (32'(y_r) < VS_END);
    row_active_s      = (32'(y_r) < V_ACTIVE);
    active_s          = (32'(x_r) < H_ACTIVE) && row_active_s;
    // Row after this one is active: row 0 after wrap, else y+1 in range.
    next_row_active_s = v_last_s ? 1'b1 : ((32'(y_r) + 32'd1) < V_ACTIVE);
    line_adv_s        = h_last_s && row_active_s && (vc_r == 2'd0);
    // The index stops advancing on the last active pixel so it never
    // runs past the active line during blanking.
    h_scan_s          = (32'(x_r) < (H_ACTIVE - 1));
    // New frame's scale is used by the replicate counters in the same
    // clock it is latched, so the first pixel of a frame is not stretched
    // by the previous frame's factor.
    pw_next_s         = frame_end_s ? pixel_width  : pw_r;
    ph_next_s         = frame_end_s ? pixel_height : ph_r;
    pipe_out_s        = pipe_r[LAT-1];
  end

  // Horizontal and vertical position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r <= '0;
      y_r <= '0;
    end else if (h_last_s) begin
      x_r <= '0;
      y_r <= v_last_s ? '0 : (y_r + Y_ONE);
    end else begin
      x_r <= x_r + X_ONE;
      y_r <= y_r;
    end
  end

  // Latch replication factors once per frame, at the very last clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pw_r <= 2'd0;
      ph_r <= 2'd0;
    end else begin
      pw_r <= pw_next_s;
      ph_r <= ph_next_s;
    end
  end

  // Horizontal replicate counter and line-buffer read address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_r  <= 2'd0;
      idx_r <= '0;
    end else if (h_last_s) begin
      hc_r  <= pw_next_s;
      idx_r <= '0;
    end else if (h_scan_s) begin
      if (hc_r == 2'd0) begin
        hc_r  <= pw_r;
        idx_r <= idx_r + IDX_ONE;
      end else begin
        hc_r  <= hc_r - 2'd1;
        idx_r <= idx_r;
      end
    end else begin
      hc_r  <= hc_r;
      idx_r <= idx_r;
    end
  end

  // Vertical replicate counter and source line index for the next row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vc_r       <= 2'd0;
      line_idx_r <= 10'd0;
    end else if (frame_end_s) begin
      vc_r       <= ph_next_s;
      line_idx_r <= 10'd0;
    end else if (h_last_s && row_active_s) begin
      if (vc_r == 2'd0) begin
        vc_r       <= ph_r;
        line_idx_r <= line_idx_r + 10'd1;
      end else begin
        vc_r       <= vc_r - 2'd1;
        line_idx_r <= line_idx_r;
      end
    end else begin
      vc_r       <= vc_r;
      line_idx_r <= line_idx_r;
    end
  end

  // Fetch request at the start of an active row needing a new source line,
  // and the frame-start strobe coinciding with x = 0, y = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_req_r    <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      line_req_r    <= h_last_s && next_row_active_s && (v_last_s || line_adv_s);
      frame_start_r <= frame_end_s;
    end
  end

  // Delay {hsync, vsync, active} by the line-buffer read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_r[i] <= 3'b000;
      end
    end else begin
      pipe_r[0] <= {hsync_s, vsync_s, active_s};
      for (int i = 1; i < LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  // Pin register: sync polarity, data enable and blank-forced colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_r <= ~HS_ON;
      vsync_r <= ~VS_ON;
      de_r    <= 1'b0;
      rgb_r   <= '0;
    end else begin
      hsync_r <= pipe_out_s[2] ? HS_ON : ~HS_ON;
      vsync_r <= pipe_out_s[1] ? VS_ON : ~VS_ON;
      de_r    <= pipe_out_s[0];
      rgb_r   <= pipe_out_s[0] ? linebuf_rgb_data : '0;
    end
  end

  assign linebuf_idx = idx_r;
  assign line_idx    = line_idx_r;
  assign line_req    = line_req_r;
  assign frame_start = frame_start_r;
  assign vga_hsync   = hsync_r;
  assign vga_vsync   = vsync_r;
  assign vga_de      = de_r;
  assign vga_r       = rgb_r[CW-1 -: COLOR_BITS];
  assign vga_g       = rgb_r[2*COLOR_BITS-1 -: COLOR_BITS];
  assign vga_b       = rgb_r[COLOR_BITS-1:0];

endmodule

// File: tb/tb_video_vga_timing.sv
// Bench for video_vga_timing with a reduced raster. Expected values come
// from arithmetic on the bench's own cycle count since reset release.
module tb_video_vga_timing;

  localparam int HA  = 32;
  localparam int HFP = 4;
  localparam int HS  = 6;
  localparam int HBP = 6;
  localparam int VA  = 20;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int L   = 3;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FT  = HT * VT;
  localparam logic HP = 1'b0;
  localparam logic VP = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pixel_width;
  logic [1:0]  pixel_height;
  logic [10:0] linebuf_idx;
  logic [11:0] linebuf_rgb_data;
  logic        line_req;
  logic [9:0]  line_idx;
  logic        frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, vga_de;

  int k;
  int sc_w [64];
  int sc_h [64];
  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] hist [L];

  always #5 clk = ~clk;

  video_vga_timing #(
    .H_ACTIVE(HA), .H_FRONT_PORCH(HFP), .H_SYNC(HS), .H_BACK_PORCH(HBP),
    .V_ACTIVE(VA), .V_FRONT_PORCH(VFP), .V_SYNC(VS), .V_BACK_PORCH(VBP),
    .HSYNC_POL(0), .VSYNC_POL(1), .COLOR_BITS(4), .IDX_W(11),
    .LINEBUF_LATENCY(L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_width(pixel_width), .pixel_height(pixel_height),
    .linebuf_idx(linebuf_idx), .linebuf_rgb_data(linebuf_rgb_data),
    .line_req(line_req), .line_idx(line_idx), .frame_start(frame_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de)
  );

  function automatic logic [11:0] pix(int i);
    logic [31:0] v;
    v = i * 37 + 5;
    return v[11:0];
  endfunction

  // Line-buffer model: data for an address appears L clocks later.
  always @(posedge clk) begin
    hist[0] <= linebuf_idx;
    for (int i = 1; i < L; i++) hist[i] <= hist[i-1];
  end
  assign linebuf_rgb_data = pix(int'(hist[L-1]));

  function automatic int xs(int kk); return kk % HT; endfunction
  function automatic int ys(int kk); return (kk / HT) % VT; endfunction
  function automatic int fr(int kk); return kk / FT; endfunction

  function automatic int exp_idx(int kk);
    int xm;
    xm = (xs(kk) < HA) ? xs(kk) : HA - 1;
    return xm / (sc_w[fr(kk)] + 1);
  endfunction

  function automatic int exp_lidx(int kk);
    int ym;
    ym = (ys(kk) < VA) ? ys(kk) : VA;
    return ym / (sc_h[fr(kk)] + 1);
  endfunction

  function automatic logic exp_lreq(int kk);
    return (kk > 0) && (xs(kk) == 0) && (ys(kk) < VA) && ((ys(kk) % (sc_h[fr(kk)] + 1)) == 0);
  endfunction

  function automatic logic exp_fs(int kk);
    return (kk > 0) && (xs(kk) == 0) && (ys(kk) == 0);
  endfunction

  function automatic logic exp_de(int kk);
    int j;
    j = kk - L - 1;
    if (j < 0) return 1'b0;
    return (xs(j) < HA) && (ys(j) < VA);
  endfunction

  function automatic logic exp_hs(int kk);
    int j;
    j = kk - L - 1;
    if (j < 0) return ~HP;
    return ((xs(j) >= HA + HFP) && (xs(j) < HA + HFP + HS)) ? HP : ~HP;
  endfunction

  function automatic logic exp_vs(int kk);
    int j;
    j = kk - L - 1;
    if (j < 0) return ~VP;
    return ((ys(j) >= VA + VFP) && (ys(j) < VA + VFP + VS)) ? VP : ~VP;
  endfunction

  function automatic logic [11:0] exp_rgb(int kk);
    if (!exp_de(kk)) return 12'h000;
    return pix(exp_idx(kk - L - 1));
  endfunction

  function automatic logic [37:0] exp_all(int kk);
    return {11'(exp_idx(kk)), 10'(exp_lidx(kk)), exp_lreq(kk), exp_fs(kk),
            exp_rgb(kk), exp_de(kk), exp_hs(kk), exp_vs(kk)};
  endfunction

  function automatic logic [37:0] obs_all();
    return {linebuf_idx, line_idx, line_req, frame_start, vga_r, vga_g, vga_b,
            vga_de, vga_hsync, vga_vsync};
  endfunction

  // Advance one clock; records the scale the DUT latches at frame end.
  task automatic tick();
    if (xs(k) == HT - 1 && ys(k) == VT - 1) begin
      sc_w[fr(k) + 1] = int'(pixel_width);
      sc_h[fr(k) + 1] = int'(pixel_height);
    end
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic restart_model();
    k = 0;
    for (int i = 0; i < 64; i++) begin
      sc_w[i] = 0;
      sc_h[i] = 0;
    end
  endtask

  task automatic next_frame();
    do tick(); while ((k % FT) != 0);
  endtask

  localparam logic [37:0] RST_VEC = {11'd0, 10'd0, 1'b0, 1'b0, 12'd0, 1'b0, ~HP, ~VP};

  task automatic test_reset();
    rst_n = 1'b0;
    pixel_width = 2'd3;
    pixel_height = 2'd3;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_all() !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", obs_all(), RST_VEC);
    end
    pixel_width = 2'd0;
    pixel_height = 2'd0;
    rst_n = 1'b1;
    restart_model();
  endtask

  task automatic test_default_timing();
    int de_cnt = 0;
    int run = 0;
    logic [3:0] e4, o4;
    repeat (2 * FT) begin
      e4 = {exp_hs(k), exp_vs(k), exp_de(k), exp_fs(k)};
      o4 = {vga_hsync, vga_vsync, vga_de, frame_start};
      n_checks++;
      if (o4 !== e4) begin
        n_fail++;
        $display("FAIL timing k=%0d: got hs/vs/de/fs %b expected %b", k, o4, e4);
      end
      n_checks++;
      if ({vga_r, vga_g, vga_b} !== exp_rgb(k)) begin
        n_fail++;
        $display("FAIL colour k=%0d: got %h expected %h", k, {vga_r, vga_g, vga_b}, exp_rgb(k));
      end
      if (vga_de === 1'b1) de_cnt++;
      if (vga_hsync === HP) run++;
      else begin
        if (run != 0) begin
          n_checks++;
          if (run != HS) begin
            n_fail++;
            $display("FAIL hsync_width: got %0d expected %0d", run, HS);
          end
        end
        run = 0;
      end
      tick();
    end
    n_checks++;
    if (de_cnt != 2 * HA * VA) begin
      n_fail++;
      $display("FAIL de_count: got %0d expected %0d", de_cnt, 2 * HA * VA);
    end
  endtask

  task automatic test_hscale();
    int mx = 0;
    pixel_width = 2'd2;
    next_frame();
    repeat (FT) begin
      n_checks++;
      if (int'(linebuf_idx) != exp_idx(k)) begin
        n_fail++;
        $display("FAIL hscale_idx k=%0d: got %0d expected %0d", k, linebuf_idx, exp_idx(k));
      end
      n_checks++;
      if ({vga_r, vga_g, vga_b} !== exp_rgb(k)) begin
        n_fail++;
        $display("FAIL hscale_colour k=%0d: got %h expected %h", k, {vga_r, vga_g, vga_b}, exp_rgb(k));
      end
      if (int'(linebuf_idx) > mx) mx = int'(linebuf_idx);
      if (xs(k) == HT - 1) begin
        n_checks++;
        if (mx != (HA - 1) / 3) begin
          n_fail++;
          $display("FAIL hscale_max k=%0d: got %0d expected %0d", k, mx, (HA - 1) / 3);
        end
        mx = 0;
      end
      tick();
    end
    pixel_width = 2'd0;
  endtask

  task automatic test_vscale();
    int reqs = 0;
    pixel_height = 2'd1;
    next_frame();
    repeat (FT) begin
      n_checks++;
      if (line_req !== exp_lreq(k) || int'(line_idx) != exp_lidx(k)) begin
        n_fail++;
        $display("FAIL vscale k=%0d: got req=%b idx=%0d expected req=%b idx=%0d",
                 k, line_req, line_idx, exp_lreq(k), exp_lidx(k));
      end
      if (line_req === 1'b1) reqs++;
      tick();
    end
    n_checks++;
    if (reqs != VA / 2) begin
      n_fail++;
      $display("FAIL vscale_req_count: got %0d expected %0d", reqs, VA / 2);
    end
    pixel_height = 2'd0;
  endtask

  task automatic test_midframe_change();
    int f0;
    next_frame();
    f0 = fr(k);
    repeat (2 * FT) begin
      if (fr(k) == f0 && ys(k) == 10 && xs(k) == 0) pixel_width = 2'd3;
      n_checks++;
      if (int'(linebuf_idx) != exp_idx(k)) begin
        n_fail++;
        $display("FAIL midframe_idx k=%0d: got %0d expected %0d", k, linebuf_idx, exp_idx(k));
      end
      tick();
    end
    pixel_width = 2'd0;
  endtask

  task automatic test_random();
    repeat (6 * FT) begin
      if ($urandom_range(0, 199) == 0) begin
        pixel_width  = 2'($urandom_range(0, 3));
        pixel_height = 2'($urandom_range(0, 3));
      end
      n_checks++;
      if (obs_all() !== exp_all(k)) begin
        n_fail++;
        $display("FAIL random k=%0d: got %h expected %h", k, obs_all(), exp_all(k));
      end
      tick();
    end
    pixel_width = 2'd0;
    pixel_height = 2'd0;
  endtask

  task automatic test_reset_midframe();
    next_frame();
    while (!(xs(k) == HA + HFP + L + 4 && ys(k) == VA + VFP)) tick();
    n_checks++;
    if (vga_hsync !== HP || vga_vsync !== VP) begin
      n_fail++;
      $display("FAIL pre_reset_sync: got hs=%b vs=%b expected hs=%b vs=%b", vga_hsync, vga_vsync, HP, VP);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs_all() !== RST_VEC) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", obs_all(), RST_VEC);
    end
    @(negedge clk);
    n_checks++;
    if (obs_all() !== RST_VEC) begin
      n_fail++;
      $display("FAIL held_reset: got %h expected %h", obs_all(), RST_VEC);
    end
    rst_n = 1'b1;
    restart_model();
    repeat (FT + HT) begin
      n_checks++;
      if (obs_all() !== exp_all(k)) begin
        n_fail++;
        $display("FAIL post_reset k=%0d: got %h expected %h", k, obs_all(), exp_all(k));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_default_timing();
    test_hscale();
    test_vscale();
    test_midframe_change();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
